fifo_dispatch_ctrl: RTL

Drain-side controller for the shared slave FIFO that the two-slave arbiter fills. It pops tagged words from the FIFO and presents them one at a time to the processing master over a valid/ready handshake. It tracks per-source frame position (FRAME_WORDS words per frame), marks the last word of each frame, and pulses `mstr0_cmplt` when a frame finishes. It also flags malformed frames: mode change mid-frame, or idle-mode words.

---
 rtl/fifo_dispatch_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/fifo_dispatch_ctrl.sv
// fifo_dispatch_ctrl: drains the shared slave FIFO one word at a time onto a
// valid/ready master port, tracking per-source frame position, frame
// completion and malformed frames.
module fifo_dispatch_ctrl #(
    parameter int unsigned DW          = 32,
    parameter int unsigned FRAME_WORDS = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           fifo_empty,
    output logic           fifo_rd_en,
    input  logic [DW+10:0] fifo_rdata,
    output logic           mstr_valid,
    input  logic           mstr_ready,
    output logic [DW-1:0]  mstr_data,
    output logic [7:0]     mstr_proc_val,
    output logic [1:0]     mstr_mode,
    output logic           mstr_src,
    output logic           mstr_last,
    output logic           mstr0_cmplt,
    output logic           frame_err,
    input  logic           err_clr,
    output logic [15:0]    frames_done0,
    output logic [15:0]    frames_done1
);

    localparam int unsigned CW = $clog2(FRAME_WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_SEND
    } state_e;

    state_e          state_q, state_d;
    logic            rd_en_q, rd_en_d;
    logic            valid_q, valid_d;
    logic [DW-1:0]   data_q, data_d;
    logic [7:0]      pval_q, pval_d;
    logic [1:0]      mode_q, mode_d;
    logic            src_q, src_d;
    logic            last_q, last_d;
    logic            cmplt_q, cmplt_d;
    logic            err_q, err_d;
    logic [CW-1:0]   cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic [1:0]      lock0_q, lock0_d, lock1_q, lock1_d;
    logic [15:0]     done0_q, done0_d, done1_q, done1_d;

    logic            err_set;
    logic [CW-1:0]   cur_cnt, new_cnt;
    logic [1:0]      cur_lock, new_lock;
    logic [1:0]      rd_mode;
    logic            rd_src;

    assign rd_mode = fifo_rdata[DW+9:DW+8];
    assign rd_src  = fifo_rdata[DW+10];

    // Next-state and next-output logic for the dispatch FSM and frame tracking
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        pval_d   = pval_q;
        mode_d   = mode_q;
        src_d    = src_q;
        last_d   = last_q;
        cmplt_d  = 1'b0;
        cnt0_d   = cnt0_q;
        cnt1_d   = cnt1_q;
        lock0_d  = lock0_q;
        lock1_d  = lock1_q;
        done0_d  = done0_q;
        done1_d  = done1_q;
        err_set  = 1'b0;
        cur_cnt  = src_q ? cnt1_q : cnt0_q;
        cur_lock = src_q ? lock1_q : lock0_q;
        new_cnt  = cur_cnt;
        new_lock = cur_lock;

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_RD;
            end
            S_RD: begin
                state_d = S_CAP;
            end
            S_CAP: begin
                if (rd_mode == 2'b00) begin
                    err_set = 1'b1;
                    state_d = fifo_empty ? S_IDLE : S_RD;
                end else begin
                    data_d  = fifo_rdata[DW-1:0];
                    pval_d  = fifo_rdata[DW+7:DW];
                    mode_d  = rd_mode;
                    src_d   = rd_src;
                    last_d  = ((rd_src ? cnt1_q : cnt0_q) == LAST_IDX);
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (mstr_ready) begin
                    state_d = fifo_empty ? S_IDLE : S_RD;
                    // Frame bookkeeping for the accepted word's source
                    if (cur_cnt == '0) begin
                        new_lock = mode_q;
                    end else if (mode_q != cur_lock) begin
                        err_set = 1'b1;
                    end
                    if (last_q) begin
                        new_cnt = '0;
                        cmplt_d = 1'b1;
                    end else begin
                        new_cnt = cur_cnt + CW'(1);
                    end
                    if (src_q) begin
                        cnt1_d  = new_cnt;
                        lock1_d = new_lock;
                        if (last_q) done1_d = done1_q + 16'd1;
                    end else begin
                        cnt0_d  = new_cnt;
                        lock0_d = new_lock;
                        if (last_q) done0_d = done0_q + 16'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        rd_en_d = (state_d == S_RD);
        valid_d = (state_d == S_SEND);

        // A new error outranks a simultaneous clear
        err_d = err_q;
        if (err_clr) err_d = 1'b0;
        if (err_set) err_d = 1'b1;
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rd_en_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            pval_q  <= '0;
            mode_q  <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b0;
            cmplt_q <= 1'b0;
            err_q   <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            lock0_q <= '0;
            lock1_q <= '0;
            done0_q <= '0;
            done1_q <= '0;
        end else begin
            state_q <= state_d;
            rd_en_q <= rd_en_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            pval_q  <= pval_d;
            mode_q  <= mode_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cmplt_q <= cmplt_d;
            err_q   <= err_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            lock0_q <= lock0_d;
            lock1_q <= lock1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
        end
    end

    assign fifo_rd_en    = rd_en_q;
    assign mstr_valid    = valid_q;
    assign mstr_data     = data_q;
    assign mstr_proc_val = pval_q;
    assign mstr_mode     = mode_q;
    assign mstr_src      = src_q;
    assign mstr_last     = last_q;
    assign mstr0_cmplt   = cmplt_q;
    assign frame_err     = err_q;
    assign frames_done0  = done0_q;
    assign frames_done1  = done1_q;

endmodule
